// File: rtl/retire_controller.sv
// Retire/commit controller at the head of the active list: per-lane commit decision, recovery handshake, deadlock watchdog.
// Define RETIRE_PERF_COUNTERS_EN to build the retired-op and recovery performance counters.
module retire_controller #(
  parameter int COMMIT_WIDTH       = 2,
  parameter int AL_CNT_W           = 7,
  parameter int MAX_INSN_PER_CYCLE = COMMIT_WIDTH,
  parameter int DEADLOCK_CYCLES    = 500,
  parameter int PERF_CNT_W         = 32,
  localparam int NUM_W             = $clog2(COMMIT_WIDTH + 1),
  localparam int IDX_W             = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1,
  localparam int EXEC_W            = 4,
  localparam int REFETCH_W         = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                phase_commit,
  input  logic [AL_CNT_W-1:0]                 al_count,
  input  logic [COMMIT_WIDTH-1:0][EXEC_W-1:0] head_exec_state,
  input  logic [COMMIT_WIDTH-1:0]             head_last,
  input  logic [COMMIT_WIDTH-1:0]             head_is_branch,
  input  logic [COMMIT_WIDTH-1:0]             head_is_store,
  input  logic [COMMIT_WIDTH-1:0]             head_is_load,
  input  logic                                recovery_busy,
  input  logic                                recovery_ack,
  input  logic                                recovery_done,
  output logic [COMMIT_WIDTH-1:0]             commit_mask,
  output logic [NUM_W-1:0]                    commit_num,
  output logic [NUM_W-1:0]                    commit_load_num,
  output logic [NUM_W-1:0]                    commit_store_num,
  output logic                                recovery_req,
  output logic [IDX_W-1:0]                    recovery_index,
  output logic [REFETCH_W-1:0]                refetch_type,
  output logic [EXEC_W-1:0]                   recovery_cause,
  output logic                                deadlock,
  output logic [PERF_CNT_W-1:0]               perf_ops,
  output logic [PERF_CNT_W-1:0]               perf_recoveries
);

  // ExecutionState encoding; every code from 9 upward is a non-misaligned-fetch fault.
  localparam logic [EXEC_W-1:0] EXEC_STATE_SUCCESS               = 4'd0;
  localparam logic [EXEC_W-1:0] EXEC_STATE_NOT_FINISHED          = 4'd1;
  localparam logic [EXEC_W-1:0] EXEC_STATE_REFETCH_NEXT          = 4'd2;
  localparam logic [EXEC_W-1:0] EXEC_STATE_REFETCH_THIS          = 4'd3;
  localparam logic [EXEC_W-1:0] EXEC_STATE_STORE_LOAD_FWD_MISS   = 4'd4;
  localparam logic [EXEC_W-1:0] EXEC_STATE_TRAP_ECALL            = 4'd5;
  localparam logic [EXEC_W-1:0] EXEC_STATE_TRAP_EBREAK           = 4'd6;
  localparam logic [EXEC_W-1:0] EXEC_STATE_TRAP_MRET             = 4'd7;
  localparam logic [EXEC_W-1:0] EXEC_STATE_FAULT_INSN_MISALIGNED = 4'd8;

  localparam logic [REFETCH_W-1:0] REFETCH_TYPE_THIS_PC               = 3'd0;
  localparam logic [REFETCH_W-1:0] REFETCH_TYPE_NEXT_PC               = 3'd1;
  localparam logic [REFETCH_W-1:0] REFETCH_TYPE_STORE_NEXT_PC         = 3'd2;
  localparam logic [REFETCH_W-1:0] REFETCH_TYPE_BRANCH_TARGET         = 3'd3;
  localparam logic [REFETCH_W-1:0] REFETCH_TYPE_THIS_PC_TO_CSR_TARGET = 3'd4;
  localparam logic [REFETCH_W-1:0] REFETCH_TYPE_NEXT_PC_TO_CSR_TARGET = 3'd5;

  localparam int WD_W = $clog2(DEADLOCK_CYCLES + 1);

  typedef enum logic [1:0] {RUN, REQ, WAIT} stateT;

  stateT state, nextState;

  logic                                finishChain;
  logic [NUM_W-1:0]                    finishedCnt;
  logic [NUM_W-1:0]                    insnCnt;
  logic [NUM_W-1:0]                    insnRange;
  logic [IDX_W-1:0]                    curHead, curTail;
  logic [COMMIT_WIDTH-1:0][IDX_W-1:0]  headOf, tailOf;
  logic                                laneFault, laneTail;
  logic [IDX_W-1:0]                    lanePoint;
  logic [REFETCH_W-1:0]                laneType;
  logic                                trigger, trigTail;
  logic [IDX_W-1:0]                    trigLane, trigPoint;
  logic [REFETCH_W-1:0]                trigType;
  logic [EXEC_W-1:0]                   trigCause;
  logic [NUM_W-1:0]                    commitCnt;
  logic [WD_W-1:0]                     stallCnt;
  logic                                stallClear;

  // Finished prefix, whole-instruction retire window, and the instruction boundaries around each lane.
  always_comb begin
    finishedCnt = '0;
    finishChain = 1'b1;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (finishChain && (i < int'(al_count)) && (head_exec_state[i] != EXEC_STATE_NOT_FINISHED))
        finishedCnt = NUM_W'(i + 1);
      else
        finishChain = 1'b0;
    end
    insnRange = '0;
    insnCnt   = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if ((i < int'(finishedCnt)) && head_last[i] && (int'(insnCnt) < MAX_INSN_PER_CYCLE)) begin
        insnCnt   = insnCnt + NUM_W'(1);
        insnRange = NUM_W'(i + 1);
      end
    end
    curHead = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      headOf[i] = curHead;
      if (head_last[i]) curHead = IDX_W'(i + 1);
    end
    curTail = IDX_W'(COMMIT_WIDTH - 1);
    for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
      if (head_last[i]) curTail = IDX_W'(i);
      tailOf[i] = curTail;
    end
  end

  // Pick the lane whose recovery point is earliest; a strict compare leaves ties with the lowest lane.
  always_comb begin
    trigger   = 1'b0;
    trigTail  = 1'b0;
    trigLane  = '0;
    trigPoint = '0;
    trigType  = REFETCH_TYPE_THIS_PC;
    trigCause = EXEC_STATE_SUCCESS;
    laneFault = 1'b0;
    laneTail  = 1'b0;
    lanePoint = '0;
    laneType  = REFETCH_TYPE_THIS_PC;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      laneFault = (i < int'(insnRange));
      laneTail  = 1'b0;
      lanePoint = headOf[i];
      laneType  = REFETCH_TYPE_THIS_PC;
      case (head_exec_state[i])
        EXEC_STATE_SUCCESS, EXEC_STATE_NOT_FINISHED: laneFault = 1'b0;
        EXEC_STATE_REFETCH_NEXT: begin
          laneTail  = 1'b1;
          lanePoint = tailOf[i];
          laneType  = head_is_branch[i] ? REFETCH_TYPE_BRANCH_TARGET :
                      head_is_store[i]  ? REFETCH_TYPE_STORE_NEXT_PC : REFETCH_TYPE_NEXT_PC;
        end
        EXEC_STATE_REFETCH_THIS, EXEC_STATE_STORE_LOAD_FWD_MISS: laneType = REFETCH_TYPE_THIS_PC;
        EXEC_STATE_TRAP_ECALL, EXEC_STATE_TRAP_EBREAK, EXEC_STATE_TRAP_MRET,
        EXEC_STATE_FAULT_INSN_MISALIGNED: begin
          laneTail  = 1'b1;
          lanePoint = tailOf[i];
          laneType  = REFETCH_TYPE_NEXT_PC_TO_CSR_TARGET;
        end
        default: laneType = REFETCH_TYPE_THIS_PC_TO_CSR_TARGET;
      endcase
      if (laneFault && (!trigger || (lanePoint < trigPoint))) begin
        trigger   = 1'b1;
        trigTail  = laneTail;
        trigLane  = IDX_W'(i);
        trigPoint = lanePoint;
        trigType  = laneType;
        trigCause = head_exec_state[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (phase_commit && trigger && !recovery_busy) nextState = REQ;
      REQ:     if (recovery_ack) nextState = WAIT;
      WAIT:    if (recovery_done) nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // The op at the recovery point itself retires only for tail-type causes that are handed off this cycle.
  always_comb begin
    commitCnt = '0;
    if ((state == RUN) && phase_commit) begin
      if (!trigger) commitCnt = insnRange;
      else          commitCnt = NUM_W'(trigPoint) + NUM_W'(trigTail && !recovery_busy);
    end
    commit_num       = commitCnt;
    commit_mask      = '0;
    commit_load_num  = '0;
    commit_store_num = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_mask[i]   = (i < int'(commitCnt));
      commit_load_num  = commit_load_num + NUM_W'(commit_mask[i] && head_is_load[i]);
      commit_store_num = commit_store_num + NUM_W'(commit_mask[i] && head_is_store[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recovery_req   <= 1'b0;
      recovery_index <= '0;
      refetch_type   <= REFETCH_TYPE_THIS_PC;
      recovery_cause <= EXEC_STATE_SUCCESS;
    end else begin
      recovery_req <= (nextState == REQ);
      if ((state == RUN) && (nextState == REQ)) begin
        recovery_index <= trigLane;
        refetch_type   <= trigType;
        recovery_cause <= trigCause;
      end
    end
  end

  assign stallClear = commit_mask[0] || recovery_done;

  // The flag is raised on the cycle that completes the DEADLOCK_CYCLES-th consecutive stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      deadlock <= 1'b0;
    end else begin
      if (stallClear)                             stallCnt <= '0;
      else if (stallCnt < WD_W'(DEADLOCK_CYCLES)) stallCnt <= stallCnt + WD_W'(1);
      if (!stallClear && (stallCnt >= WD_W'(DEADLOCK_CYCLES - 1))) deadlock <= 1'b1;
    end
  end

`ifdef RETIRE_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ops        <= '0;
      perf_recoveries <= '0;
    end else begin
      perf_ops <= perf_ops + PERF_CNT_W'(commit_num);
      if ((state != REQ) && (nextState == REQ)) perf_recoveries <= perf_recoveries + PERF_CNT_W'(1);
    end
  end
`else
  assign perf_ops        = '0;
  assign perf_recoveries = '0;
`endif

endmodule

// File: tb/tb_retire_controller.sv
// Directed self-checking bench for retire_controller (4 lanes), plus a 2-instruction-per-cycle instance.
module tb_retire_controller;

  localparam logic [3:0] EX_SUCCESS      = 4'd0;
  localparam logic [3:0] EX_NOT_FINISHED = 4'd1;
  localparam logic [3:0] EX_REFETCH_NEXT = 4'd2;
  localparam logic [3:0] EX_REFETCH_THIS = 4'd3;
  localparam logic [3:0] EX_TRAP_ECALL   = 4'd5;
  localparam logic [3:0] EX_FAULT_LOAD   = 4'd9;

  localparam logic [2:0] RT_THIS_PC       = 3'd0;
  localparam logic [2:0] RT_STORE_NEXT_PC = 3'd2;
  localparam logic [2:0] RT_BRANCH_TARGET = 3'd3;
  localparam logic [2:0] RT_THIS_TO_CSR   = 3'd4;
  localparam logic [2:0] RT_NEXT_TO_CSR   = 3'd5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            phaseCommit = 1'b0;
  logic [6:0]      alCount = '0;
  logic [3:0][3:0] headState = '0;
  logic [3:0]      headLast = '0, headBranch = '0, headStore = '0, headLoad = '0;
  logic            busy = 1'b0, ack = 1'b0, done = 1'b0;

  logic [3:0]  mask, mask2;
  logic [2:0]  num, loadNum, storeNum, num2, loadNum2, storeNum2;
  logic        req, req2, dead, dead2;
  logic [1:0]  idx, idx2;
  logic [2:0]  rtype, rtype2;
  logic [3:0]  cause, cause2;
  logic [31:0] perfOps, perfRecs, perfOps2, perfRecs2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  retire_controller #(.COMMIT_WIDTH(4), .DEADLOCK_CYCLES(500)) dut (
    .clk(clk), .rst(rst), .phase_commit(phaseCommit), .al_count(alCount),
    .head_exec_state(headState), .head_last(headLast), .head_is_branch(headBranch),
    .head_is_store(headStore), .head_is_load(headLoad), .recovery_busy(busy),
    .recovery_ack(ack), .recovery_done(done), .commit_mask(mask), .commit_num(num),
    .commit_load_num(loadNum), .commit_store_num(storeNum), .recovery_req(req),
    .recovery_index(idx), .refetch_type(rtype), .recovery_cause(cause), .deadlock(dead),
    .perf_ops(perfOps), .perf_recoveries(perfRecs));

  retire_controller #(.COMMIT_WIDTH(4), .MAX_INSN_PER_CYCLE(2)) dutNarrow (
    .clk(clk), .rst(rst), .phase_commit(phaseCommit), .al_count(alCount),
    .head_exec_state(headState), .head_last(headLast), .head_is_branch(headBranch),
    .head_is_store(headStore), .head_is_load(headLoad), .recovery_busy(busy),
    .recovery_ack(ack), .recovery_done(done), .commit_mask(mask2), .commit_num(num2),
    .commit_load_num(loadNum2), .commit_store_num(storeNum2), .recovery_req(req2),
    .recovery_index(idx2), .refetch_type(rtype2), .recovery_cause(cause2), .deadlock(dead2),
    .perf_ops(perfOps2), .perf_recoveries(perfRecs2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // States are listed lane3..lane0, so the low nibble is the head lane.
  task automatic applyStimulus(input logic [15:0] states, input logic [3:0] last,
                               input logic [3:0] branch, input logic [3:0] store,
                               input logic [3:0] load, input logic [6:0] count);
    headState   = states;
    headLast    = last;
    headBranch  = branch;
    headStore   = store;
    headLoad    = load;
    alCount     = count;
    phaseCommit = 1'b1;
    #1;
  endtask

  task automatic finishRecovery();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", req); end
    checks++; if (idx !== 2'd0) begin failures++; $display("FAIL reset_index got=%0d want=0", idx); end
    checks++; if (rtype !== RT_THIS_PC) begin failures++; $display("FAIL reset_type got=%0d want=%0d", rtype, RT_THIS_PC); end
    checks++; if (cause !== EX_SUCCESS) begin failures++; $display("FAIL reset_cause got=%0d want=%0d", cause, EX_SUCCESS); end
    checks++; if (dead !== 1'b0) begin failures++; $display("FAIL reset_deadlock got=%b want=0", dead); end
    checks++; if (mask !== 4'b0000) begin failures++; $display("FAIL reset_mask got=%b want=0000", mask); end
    checks++; if ({req2, idx2, rtype2, cause2, dead2} !== 11'd0) begin failures++; $display("FAIL reset_narrow got=%b want=0", {req2, idx2, rtype2, cause2, dead2}); end
    checks++; if ({perfOps, perfRecs, perfOps2, perfRecs2} !== 128'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perfOps, perfRecs); end
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic test_full_commit();
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b1000, 4'b0101, 7'd4);
    checks++; if (mask !== 4'b1111) begin failures++; $display("FAIL full_mask got=%b want=1111", mask); end
    checks++; if (num !== 3'd4) begin failures++; $display("FAIL full_num got=%0d want=4", num); end
    checks++; if (loadNum !== 3'd2) begin failures++; $display("FAIL full_loads got=%0d want=2", loadNum); end
    checks++; if (storeNum !== 3'd1) begin failures++; $display("FAIL full_stores got=%0d want=1", storeNum); end
    checks++; if (mask2 !== 4'b0011) begin failures++; $display("FAIL maxinsn_mask got=%b want=0011", mask2); end
    checks++; if ({num2, loadNum2, storeNum2} !== {3'd2, 3'd1, 3'd0}) begin failures++; $display("FAIL maxinsn_counts got=%0d/%0d/%0d want=2/1/0", num2, loadNum2, storeNum2); end
  endtask

  task automatic test_window();
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd2);
    checks++; if (mask !== 4'b0011) begin failures++; $display("FAIL alcount2_mask got=%b want=0011", mask); end
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd0);
    checks++; if (mask !== 4'b0000) begin failures++; $display("FAIL alcount0_mask got=%b want=0000", mask); end
    applyStimulus({4{EX_SUCCESS}}, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0111) begin failures++; $display("FAIL multiop_mask got=%b want=0111", mask); end
    applyStimulus({EX_SUCCESS, EX_NOT_FINISHED, EX_SUCCESS, EX_SUCCESS}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0011) begin failures++; $display("FAIL notfinished_mask got=%b want=0011", mask); end
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    phaseCommit = 1'b0;
    #1;
    checks++; if (mask !== 4'b0000) begin failures++; $display("FAIL nophase_mask got=%b want=0000", mask); end
  endtask

  task automatic test_branch_recovery();
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_REFETCH_NEXT, EX_SUCCESS}, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0011) begin failures++; $display("FAIL branch_mask got=%b want=0011", mask); end
    tick();
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL branch_req got=%b want=1", req); end
    checks++; if (idx !== 2'd1) begin failures++; $display("FAIL branch_index got=%0d want=1", idx); end
    checks++; if (rtype !== RT_BRANCH_TARGET) begin failures++; $display("FAIL branch_type got=%0d want=%0d", rtype, RT_BRANCH_TARGET); end
    checks++; if (cause !== EX_REFETCH_NEXT) begin failures++; $display("FAIL branch_cause got=%0d want=%0d", cause, EX_REFETCH_NEXT); end
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0000) begin failures++; $display("FAIL req_mask got=%b want=0000", mask); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (req !== 1'b1 || idx !== 2'd1) begin failures++; $display("FAIL req_hold%0d got=%b/%0d want=1/1", c, req, idx); end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL req_after_ack got=%b want=0", req); end
    checks++; if (mask !== 4'b0000) begin failures++; $display("FAIL wait_mask got=%b want=0000", mask); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (mask !== 4'b1111) begin failures++; $display("FAIL resume_mask got=%b want=1111", mask); end
  endtask

  task automatic test_busy_fault();
    busy = 1'b1;
    applyStimulus({EX_SUCCESS, EX_FAULT_LOAD, EX_SUCCESS, EX_SUCCESS}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0011) begin failures++; $display("FAIL busy_first_mask got=%b want=0011", mask); end
    tick();
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_SUCCESS, EX_FAULT_LOAD}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0000 || req !== 1'b0) begin failures++; $display("FAIL busy_wait1 got=%b/%b want=0000/0", mask, req); end
    tick();
    checks++; if (mask !== 4'b0000 || req !== 1'b0) begin failures++; $display("FAIL busy_wait2 got=%b/%b want=0000/0", mask, req); end
    busy = 1'b0;
    tick();
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL busy_req got=%b want=1", req); end
    checks++; if (rtype !== RT_THIS_TO_CSR || idx !== 2'd0 || cause !== EX_FAULT_LOAD) begin failures++; $display("FAIL busy_fields got=%0d/%0d/%0d want=%0d/0/%0d", rtype, idx, cause, RT_THIS_TO_CSR, EX_FAULT_LOAD); end
    finishRecovery();
  endtask

  task automatic test_tie_and_tail();
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_REFETCH_THIS, EX_TRAP_ECALL}, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0000) begin failures++; $display("FAIL earliest_mask got=%b want=0000", mask); end
    tick();
    checks++; if (idx !== 2'd1 || rtype !== RT_THIS_PC || cause !== EX_REFETCH_THIS) begin failures++; $display("FAIL earliest_fields got=%0d/%0d/%0d want=1/%0d/%0d", idx, rtype, cause, RT_THIS_PC, EX_REFETCH_THIS); end
    finishRecovery();
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_SUCCESS, EX_REFETCH_NEXT}, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0001) begin failures++; $display("FAIL store_mask got=%b want=0001", mask); end
    tick();
    checks++; if (rtype !== RT_STORE_NEXT_PC) begin failures++; $display("FAIL store_type got=%0d want=%0d", rtype, RT_STORE_NEXT_PC); end
    finishRecovery();
    busy = 1'b1;
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_SUCCESS, EX_TRAP_ECALL}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    checks++; if (mask !== 4'b0000) begin failures++; $display("FAIL ecall_busy_mask got=%b want=0000", mask); end
    busy = 1'b0;
    #1;
    checks++; if (mask !== 4'b0001) begin failures++; $display("FAIL ecall_mask got=%b want=0001", mask); end
    tick();
    checks++; if (rtype !== RT_NEXT_TO_CSR || cause !== EX_TRAP_ECALL) begin failures++; $display("FAIL ecall_fields got=%0d/%0d want=%0d/%0d", rtype, cause, RT_NEXT_TO_CSR, EX_TRAP_ECALL); end
    finishRecovery();
  endtask

  task automatic test_reset_mid_req();
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_SUCCESS, EX_REFETCH_THIS}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    tick();
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL midreq_setup got=%b want=1", req); end
    phaseCommit = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL midreq_abort got=%b want=0", req); end
    #1 rst = 1'b1;
    #1;
  endtask

  task automatic test_perf();
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd2);
    for (int c = 0; c < 10; c++) tick();
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_SUCCESS, EX_REFETCH_THIS}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd2);
    tick();
`ifdef RETIRE_PERF_COUNTERS_EN
    checks++; if (perfOps !== 32'd20) begin failures++; $display("FAIL perf_ops got=%0d want=20", perfOps); end
    checks++; if (perfRecs !== 32'd1) begin failures++; $display("FAIL perf_recoveries got=%0d want=1", perfRecs); end
`else
    checks++; if (perfOps !== 32'd0) begin failures++; $display("FAIL perf_ops_tied got=%0d want=0", perfOps); end
    checks++; if (perfRecs !== 32'd0) begin failures++; $display("FAIL perf_recoveries_tied got=%0d want=0", perfRecs); end
`endif
  endtask

  task automatic test_deadlock();
    rst = 1'b0;
    #1 rst = 1'b1;
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    tick();
    applyStimulus({EX_SUCCESS, EX_SUCCESS, EX_SUCCESS, EX_NOT_FINISHED}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    for (int c = 0; c < 499; c++) tick();
    checks++; if (dead !== 1'b0) begin failures++; $display("FAIL deadlock_early got=%b want=0", dead); end
    tick();
    checks++; if (dead !== 1'b1) begin failures++; $display("FAIL deadlock_set got=%b want=1", dead); end
    applyStimulus({4{EX_SUCCESS}}, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 7'd4);
    for (int c = 0; c < 3; c++) tick();
    checks++; if (dead !== 1'b1) begin failures++; $display("FAIL deadlock_sticky got=%b want=1", dead); end
    rst = 1'b0;
    #1;
    checks++; if (dead !== 1'b0) begin failures++; $display("FAIL deadlock_reset got=%b want=0", dead); end
  endtask

  initial begin
    test_reset();
    test_full_commit();
    test_window();
    test_branch_recovery();
    test_busy_fault();
    test_tie_and_tail();
    test_reset_mid_req();
    test_perf();
    test_deadlock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_controller.md
Name: retire_controller

Overview:
- Parametrised retire/commit controller at the head of the active list; decides per-lane commit for up to COMMIT_WIDTH ops per cycle, at instruction granularity.
- Successor to the fixed-width commit decision logic. Adds:
  - an instruction-count throttle;
  - a registered recovery-request handshake with the recovery manager, which holds the request until acknowledged;
  - a sticky deadlock watchdog.

Parameters:
- COMMIT_WIDTH, 2: head lanes examined per cycle; must be >= 1.
- AL_CNT_W, 7: width of the active-list valid-entry count.
- MAX_INSN_PER_CYCLE, COMMIT_WIDTH: maximum whole instructions retired per cycle; range 1..COMMIT_WIDTH.
- DEADLOCK_CYCLES, 500: cycles without retirement before `deadlock` asserts.
- PERF_CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- phase_commit  in  1  pipeline is in commit phase.
- al_count  in  AL_CNT_W  valid active-list entries.
- head_exec_state  in  COMMIT_WIDTH x ExecutionState  exec state of head lanes.
- head_last / head_is_branch / head_is_store / head_is_load  in  COMMIT_WIDTH each  per-lane flags.
- recovery_busy  in  1  recovery manager cannot accept a request this cycle.
- recovery_ack  in  1  recovery manager accepted the held request.
- recovery_done  in  1  recovery finished; retirement may resume.
- commit_mask  out  COMMIT_WIDTH  lanes retiring this cycle (combinational).
- commit_num / commit_load_num / commit_store_num  out  $clog2(COMMIT_WIDTH+1)  retiring op counts.
- recovery_req  out  1  registered recovery request.
- recovery_index  out  $clog2(COMMIT_WIDTH)  lane that caused recovery.
- refetch_type  out  RefetchType  refetch target.
- recovery_cause  out  ExecutionState  cause of recovery.
- deadlock  out  1  sticky watchdog flag.
- perf_ops / perf_recoveries  out  PERF_CNT_W  counters (optional feature only).

Behaviour:
- FSM states: RUN, REQ, WAIT. Reset (rst=0, async) -> RUN.
  - All registered outputs reset to 0: recovery_req, recovery_index, deadlock, counters.
  - refetch_type resets to REFETCH_TYPE_THIS_PC; recovery_cause to EXEC_STATE_SUCCESS.
- finishedOps: leading lanes i with i<al_count and state != NOT_FINISHED.
- insnRange: ops up to and including the last `head_last` within finishedOps, truncated after MAX_INSN_PER_CYCLE `last` bits.
- Per-lane recovery classification:
  - REFETCH_NEXT: point = tail of insn; type = BRANCH_TARGET / STORE_NEXT_PC / NEXT_PC, priority in that order (branch first, then store).
  - REFETCH_THIS or STORE_LOAD_FORWARDING_MISS: point = head of insn; type = THIS_PC.
  - TRAP_ECALL / EBREAK / MRET or FAULT_INSN_MISALIGNED: point = tail; type = NEXT_PC_TO_CSR_TARGET.
  - Other FAULT_*: point = head; type = THIS_PC_TO_CSR_TARGET.
- Trigger: the smallest point among lanes < insnRange. Ties go to the lowest lane.
- RUN with phase_commit=1:
  - No trigger: commit lanes < insnRange.
  - Trigger: commit lanes < point.
  - Lane == point commits only if its class is tail-type and recovery_busy=0.
- Trigger and recovery_busy=0:
  - Latch index, type and cause.
  - Next cycle: REQ with recovery_req=1.
- Trigger and recovery_busy=1: stay in RUN and re-evaluate next cycle.
- REQ: commit_mask=0; recovery_req and latched fields held stable until recovery_ack=1.
  - On ack: -> WAIT, recovery_req=0 the next cycle.
- WAIT: commit_mask=0; recovery_done=1 -> RUN.
  - recovery_done in RUN or REQ is ignored.
- phase_commit=0 forces commit_mask=0 in every state.
- al_count=0 -> no commit, no trigger.
- Watchdog: counts cycles with commit_mask[0]=0; clears on commit or recovery_done; saturates.
  - Reaching DEADLOCK_CYCLES sets `deadlock`, which stays set until reset.
- Reset mid-REQ aborts the request; recovery_req=0 immediately (asynchronous).

Optional Feature:
- RETIRE_PERF_COUNTERS_EN defined:
  - perf_ops += commit_num each cycle.
  - perf_recoveries += 1 on each REQ entry.
  - Both wrap modulo 2^PERF_CNT_W.
- Undefined: no counter flops; perf_ops and perf_recoveries tied to 0.

Test Plan:
- COMMIT_WIDTH=4, al_count=4, all SUCCESS, last=1111 -> commit_mask=1111, commit_num=4.
- MAX_INSN_PER_CYCLE=2, last=1111, all SUCCESS -> commit_mask=0011.
- Lane1 REFETCH_NEXT with is_branch, last=1111, busy=0 -> commit_mask=0011.
  - Next cycle recovery_req=1, index=1, type=BRANCH_TARGET.
  - recovery_req held through 3 cycles with ack=0; drops the cycle after ack.
- Lane2 FAULT_LOAD_VIOLATION, last=1111, recovery_busy=1 for 2 cycles -> commit_mask=0011 on first cycle, 0000 while waiting; state stays RUN.
  - Busy drops -> REQ; type=THIS_PC_TO_CSR_TARGET.
- Lane0 NOT_FINISHED for 500 cycles with DEADLOCK_CYCLES=500 -> deadlock=1, stays 1 after commits resume; rst low clears it.
- RETIRE_PERF_COUNTERS_EN: 10 cycles of commit_num=2, then one recovery -> perf_ops=20, perf_recoveries=1.
